// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout
    );

endinterface

// File: rtl/serial_subtractor_fullsubtractor_cell.sv
// One-bit full subtractor assembled from two dataflow half subtractors.
module halfsubtractor_df (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i;
    assign bout_o = ~a_i & b_i;

endmodule

module fullsubtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic d1;
    logic b1;
    logic b2;

    halfsubtractor_df u_hs_ab (
        .a_i    (a_i),
        .b_i    (b_i),
        .d_o    (d1),
        .bout_o (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    halfsubtractor_df u_hs_bin (
        .a_i    (d1),
        .b_i    (bin_i),
        .d_o    (d_o),
        .bout_o (b2)
    );

    assign bout_o = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one full-subtractor cell reused over WIDTH cycles.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;

    logic               bit_diff;
    logic               bit_borrow;

    fullsubtractor_cell u_cell (
        .a_i    (sa_q[0]),
        .b_i    (sb_q[0]),
        .bin_i  (brw_q),
        .d_o    (bit_diff),
        .bout_o (bit_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    sr_d    = '0;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {bit_diff, sr_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                brw_d = bit_borrow;
                cnt_d = cnt_q + CNT_W'(1);
                // The last bit lands straight in the result register, so d is complete on DONE entry.
                if (cnt_q == LAST_CNT) begin
                    d_d     = {bit_diff, sr_q[WIDTH-1:1]};
                    bout_d  = bit_borrow;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes d = a − b one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It sits downstream of the half-subtractor cell: it chains that cell into a full subtractor and sequences it over a multi-bit word. A start/busy/done handshake lets a controller issue operations at low area cost.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse; result valid
- d  output  WIDTH  difference (a − b) mod 2^WIDTH; held until the next completion
- bout  output  1  final borrow; 1 when a < b unsigned

One clock. Reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge, latch a→sa and b→sb, clear the borrow flop, clear the bit counter, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT, per edge:
  - Bit diff = sa[0] ^ sb[0] ^ brw.
  - New brw = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw).
  - Shift diff into the MSB of the result shift register (sr), right-shift sa and sb, and increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE: the edge that enters DONE loads d ← sr (complete word) and bout ← final brw. done=1 for exactly this one cycle. Next edge returns to IDLE.
- start is ignored in SHIFT and DONE. A request in those states is not queued.
- a and b may change freely after the accepting edge. They are not used again.
- d and bout change only on entry to DONE. They hold their values throughout the next computation.
- Counter width is clog2(WIDTH+1). The counter never wraps within an operation.
- Arithmetic is unsigned modulo 2^WIDTH. bout is the borrow out of bit WIDTH−1.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, d=0, bout=0, internal registers 0. Deassert is synchronised by the usual reset-release practice. The first start is honoured on the first edge after release.
- Reset mid-operation aborts. No done pulse occurs, and d/bout read 0.
- Accept edge k: busy=1 from k.
- Bits are processed on edges k+1 … k+WIDTH.
- At edge k+WIDTH: state=DONE, done=1, busy=0, d/bout valid.
- Edge k+WIDTH+1: IDLE, done=0.
- Earliest next accept: edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together. done is registered with no combinational path from inputs.
- start held high continuously: operations restart back-to-back every WIDTH+2 cycles.

## Structure
- Shared package/header serial_subtractor_pkg:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2 (2'd3 unreachable, decodes to IDLE);
  - default WIDTH.
- Sub-module fullsubtractor_cell (a, b, bin → d, bout). It is built from two halfsubtractor_df instances plus an OR of their borrows and instantiated once. The FSM, counter and shift registers stay in the top module.

## Test plan
- WIDTH=8. After reset release, check d=0, bout=0, busy=0, done=0. Then start with a=5, b=3 → done at edge k+8, d=8'h02, bout=0, busy low in the same cycle.
- a=3, b=5 → d=8'hFE, bout=1. Then a=8'h00, b=8'h01 → d=8'hFF, bout=1. Then a=8'hFF, b=8'hFF → d=8'h00, bout=0.
- Accept a=8'h10, b=8'h01. Pulse start with a=0, b=0 at edge k+3 and again during DONE → single result d=8'h0F, exactly one done pulse.
- Assert rst_n low at edge k+4 of a=8'hA5, b=8'h5A → immediate busy=0, d=0, bout=0, no done. Next operation a=9, b=4 → d=5.
- Hold start=1 continuously with varying a/b → done every 10 cycles, each result equal to the operands present at its accept edge.
- WIDTH=4, exhaustive 256 pairs → d=(a−b) mod 16 and bout=(a<b), checked against a reference model.
